// File: rtl/icache_direct.sv
// icache_direct: direct-mapped instruction cache between the IF stage and the
// memory controller's byte-wide instruction port. One 32-bit word per line.
// A hit answers one cycle after the request. A miss fetches four bytes,
// assembles them little-endian, writes the line and bypasses the word to IF.
module icache_direct #(
    parameter int INDEX_BITS = 7,
    parameter int ADDR_W     = 18
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              req_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              cancel_in,
    output logic              inst_valid_out,
    output logic [31:0]       inst_out,
    output logic              mem_req_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    input  logic              mem_valid_in,
    input  logic [7:0]        mem_data_in,
    output logic [1:0]        state_dbg
);

    localparam int LINES  = 1 << INDEX_BITS;
    localparam int TAG_W  = ADDR_W - INDEX_BITS - 2;
    localparam int WORD_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Memory-controller handshake: mem_req_out/mem_addr_out are a request that
    // stays asserted and unchanged until the controller answers with
    // mem_valid_in for one cycle; that cycle completes exactly one byte read.
    // The controller finishes a read it has seen even if the request drops,
    // which is why a cancelled fill has to wait in DRAIN for the late byte.

    // Line storage
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    // Control / datapath state
    state_t            state_q, state_d;
    logic [1:0]        count_q, count_d;
    logic [31:0]       asm_q, asm_d;
    logic [WORD_W-1:0] base_q, base_d;

    // Next values of the registered outputs
    logic              inst_valid_d;
    logic [31:0]       inst_d;
    logic              mem_req_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic              fill_we;

    // Lookup and fill address fields
    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_W-1:0]      fill_tag;
    logic                  hit;
    logic [31:0]           asm_merged;

    assign req_index  = addr_in[INDEX_BITS+1:2];
    assign req_tag    = addr_in[ADDR_W-1:INDEX_BITS+2];
    assign fill_index = base_q[INDEX_BITS-1:0];
    assign fill_tag   = base_q[WORD_W-1:INDEX_BITS];
    assign hit        = valid_q[req_index] && (tag_q[req_index] == req_tag);
    assign state_dbg  = state_q;

    // Merge the returning byte into its little-endian lane of the word
    always_comb begin
        asm_merged = asm_q;
        case (count_q)
            2'd0: asm_merged[7:0]   = mem_data_in;
            2'd1: asm_merged[15:8]  = mem_data_in;
            2'd2: asm_merged[23:16] = mem_data_in;
            2'd3: asm_merged[31:24] = mem_data_in;
        endcase
    end

    // Next-state and next-output logic for the lookup/fill controller
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        asm_d        = asm_q;
        base_d       = base_q;
        inst_valid_d = 1'b0;
        inst_d       = inst_out;
        mem_req_d    = mem_req_out;
        mem_addr_d   = mem_addr_out;
        fill_we      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // A redirect in the same cycle wins over the request
                if (req_in && !cancel_in) begin
                    if (hit) begin
                        inst_valid_d = 1'b1;
                        inst_d       = data_q[req_index];
                    end else begin
                        base_d     = addr_in[ADDR_W-1:2];
                        mem_req_d  = 1'b1;
                        mem_addr_d = addr_in;
                        count_d    = 2'd0;
                        state_d    = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (mem_valid_in) begin
                    if (cancel_in) begin
                        // Byte arrives with the redirect: nothing left outstanding
                        mem_req_d = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        asm_d = asm_merged;
                        if (count_q != 2'd3) begin
                            count_d    = count_q + 2'd1;
                            // Word aligned base, so the byte offset never carries
                            mem_addr_d = {base_q, count_q + 2'd1};
                        end else begin
                            mem_req_d    = 1'b0;
                            fill_we      = 1'b1;
                            inst_valid_d = 1'b1;
                            inst_d       = asm_merged;
                            state_d      = ST_IDLE;
                        end
                    end
                end else if (cancel_in) begin
                    // The controller still owes us one byte; swallow it in DRAIN
                    mem_req_d = 1'b0;
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (mem_valid_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, output and valid-bit registers; rdy_in low freezes everything
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q        <= ST_IDLE;
            count_q        <= 2'd0;
            asm_q          <= 32'd0;
            base_q         <= '0;
            inst_valid_out <= 1'b0;
            inst_out       <= 32'd0;
            mem_req_out    <= 1'b0;
            mem_addr_out   <= '0;
            valid_q        <= '0;
        end else if (rdy_in) begin
            state_q        <= state_d;
            count_q        <= count_d;
            asm_q          <= asm_d;
            base_q         <= base_d;
            inst_valid_out <= inst_valid_d;
            inst_out       <= inst_d;
            mem_req_out    <= mem_req_d;
            mem_addr_out   <= mem_addr_d;
            if (fill_we) begin
                valid_q[fill_index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays: written only when a fill completes uncancelled
    always_ff @(posedge clk_in) begin
        if (rst_in && rdy_in && fill_we) begin
            tag_q[fill_index]  <= fill_tag;
            data_q[fill_index] <= asm_merged;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: table-driven hit/miss sequence against a byte memory image,
// plus hand-written sequences for stalls, cancels, rdy freeze and reset.
module tb_icache_direct;
  localparam int INDEX_BITS = 7;
  localparam int ADDR_W     = 18;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // ---------------- clock / reset / DUT ----------------
  logic              clk_in = 1'b0;
  logic              rst_in, rdy_in, req_in, cancel_in;
  logic [ADDR_W-1:0] addr_in;
  logic              inst_valid_out;
  logic [31:0]       inst_out;
  logic              mem_req_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic              mem_valid_in;
  logic [7:0]        mem_data_in;
  logic [1:0]        state_dbg;

  always #5 clk_in = ~clk_in;

  icache_direct #(.INDEX_BITS(INDEX_BITS), .ADDR_W(ADDR_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .req_in(req_in),
    .addr_in(addr_in), .cancel_in(cancel_in), .inst_valid_out(inst_valid_out),
    .inst_out(inst_out), .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out),
    .mem_valid_in(mem_valid_in), .mem_data_in(mem_data_in), .state_dbg(state_dbg)
  );

  // ---------------- memory image and controller model ----------------
  logic [7:0] img [1024];
  bit         mc_en = 1'b0;
  int         mc_lat = 1;
  bit         stall_on = 1'b0;
  logic [ADDR_W-1:0] stall_addr = '0;
  int         stall_len = 0;
  int         mc_wait = 0;
  logic       mc_valid = 1'b0, man_valid = 1'b0;
  logic [7:0] mc_data = 8'd0, man_data = 8'd0;

  assign mem_valid_in = mc_en ? mc_valid : man_valid;
  assign mem_data_in  = mc_en ? mc_data  : man_data;

  function automatic logic [31:0] img_word(input logic [ADDR_W-1:0] a);
    logic [9:0] b;
    b = a[9:0];
    return {img[b + 10'd3], img[b + 10'd2], img[b + 10'd1], img[b]};
  endfunction

  function automatic int lat_of(input logic [ADDR_W-1:0] a);
    return (stall_on && a == stall_addr) ? stall_len : mc_lat;
  endfunction

  // Answers each byte request after lat_of() idle cycles
  always @(posedge clk_in) begin
    #1;
    if (mc_en && mem_req_out && rst_in) begin
      if (mc_wait >= lat_of(mem_addr_out)) begin
        mc_valid = 1'b1;
        mc_data  = img[mem_addr_out[9:0]];
        mc_wait  = 0;
      end else begin
        mc_valid = 1'b0;
        mc_wait++;
      end
    end else begin
      mc_valid = 1'b0;
      mc_wait  = 0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0]       exp_q[$];
  logic [ADDR_W-1:0] hs_addr_q[$];
  int total = 0, bad = 0;
  int resp_cnt = 0, hs_cnt = 0, stall_seen = 0;
  logic p_req = 1'b0, p_valid = 1'b0, p_cancel = 1'b0, p_rst = 1'b0;
  logic [ADDR_W-1:0] p_addr = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (inst_valid_out === 1'b1) begin
      resp_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected response: inst_out=0x%0h with nothing outstanding", inst_out);
      end else begin
        check("response data", inst_out, exp_q.pop_front());
      end
    end
    if (mem_req_out === 1'b1 && mem_valid_in && rdy_in && rst_in) begin
      hs_cnt++;
      hs_addr_q.push_back(mem_addr_out);
    end
    if (p_req && !p_valid && !p_cancel && p_rst) begin
      check("mem_req held until valid", 32'(mem_req_out), 32'd1);
      check("mem_addr held until valid", 32'(mem_addr_out), 32'(p_addr));
    end
    if (stall_on && mem_req_out === 1'b1 && !mem_valid_in && mem_addr_out == stall_addr)
      stall_seen++;
    p_req    = (mem_req_out === 1'b1);
    p_addr   = mem_addr_out;
    p_valid  = mem_valid_in;
    p_cancel = cancel_in;
    p_rst    = rst_in;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b0; rdy_in = 1'b1; req_in = 1'b0; cancel_in = 1'b0;
    addr_in = '0; mc_en = 1'b0; man_valid = 1'b0; man_data = 8'd0;
    tick();
    tick();
    rst_in = 1'b1;
  endtask

  task automatic give_byte(input logic [ADDR_W-1:0] a);
    man_valid = 1'b1;
    man_data  = img[a[9:0]];
    tick();
    man_valid = 1'b0;
  endtask

  task automatic do_req(input logic [ADDR_W-1:0] a, input bit exp_hit, input string nm);
    int r0, h0, n;
    r0 = resp_cnt;
    h0 = hs_cnt;
    hs_addr_q.delete();
    exp_q.push_back(img_word(a));
    req_in = 1'b1;
    addr_in = a;
    tick();
    req_in = 1'b0;
    if (exp_hit) begin
      check({nm, " hit valid next cycle"}, 32'(inst_valid_out), 32'd1);
      check({nm, " hit no mem_req"}, 32'(mem_req_out), 32'd0);
    end else begin
      check({nm, " miss no early valid"}, 32'(inst_valid_out), 32'd0);
      check({nm, " miss mem_req"}, 32'(mem_req_out), 32'd1);
      check({nm, " miss first addr"}, 32'(mem_addr_out), 32'(a));
      n = 0;
      while (inst_valid_out !== 1'b1 && n < 200) begin
        tick();
        n++;
      end
      if (n >= 200) begin
        total++;
        bad++;
        $display("FAIL %s timeout: no response within 200 cycles", nm);
      end
    end
    @(negedge clk_in);
    #1;
    check({nm, " one response"}, 32'(resp_cnt - r0), 32'd1);
    check({nm, " byte reads"}, 32'(hs_cnt - h0), exp_hit ? 32'd0 : 32'd4);
    if (!exp_hit && hs_addr_q.size() == 4)
      for (int k = 0; k < 4; k++)
        check({nm, " byte addr seq"}, 32'(hs_addr_q[k]), 32'(a) + 32'(k));
    tick();
    check({nm, " valid is a pulse"}, 32'(inst_valid_out), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [ADDR_W-1:0] addr;
    bit                hit;
    int                lat;
  } vec_t;
  vec_t tbl[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) img[i] = 8'($urandom_range(0, 255));
    img[10'h10] = 8'h13; img[10'h11] = 8'h05; img[10'h12] = 8'h00; img[10'h13] = 8'h00;
    img[10'h30] = 8'h93; img[10'h31] = 8'h00; img[10'h32] = 8'h10; img[10'h33] = 8'h00;

    tbl[0]  = '{18'h00010, 1'b0, 1};
    tbl[1]  = '{18'h00010, 1'b1, 0};
    tbl[2]  = '{18'h00014, 1'b0, 0};
    tbl[3]  = '{18'h00210, 1'b0, 2};
    tbl[4]  = '{18'h00014, 1'b1, 0};
    tbl[5]  = '{18'h00010, 1'b0, 1};
    tbl[6]  = '{18'h00210, 1'b0, 0};
    tbl[7]  = '{18'h003FC, 1'b0, 1};
    tbl[8]  = '{18'h003FC, 1'b1, 0};
    tbl[9]  = '{18'h3FFFC, 1'b0, 0};
    tbl[10] = '{18'h003FC, 1'b0, 2};
    tbl[11] = '{18'h00210, 1'b1, 0};

    // Reset state
    do_reset();
    check("reset inst_valid", 32'(inst_valid_out), 32'd0);
    check("reset inst_out", inst_out, 32'd0);
    check("reset mem_req", 32'(mem_req_out), 32'd0);
    check("reset mem_addr", 32'(mem_addr_out), 32'd0);
    check("reset state", 32'(state_dbg), 32'(S_IDLE));

    // Cold miss then hit
    mc_en = 1'b1; mc_lat = 1;
    do_req(18'h00010, 1'b0, "cold miss");
    check("cold miss word", inst_out, 32'h00000513);
    do_req(18'h00010, 1'b1, "cold rehit");
    check("inst_out holds", inst_out, 32'h00000513);

    // Table of hit/miss vectors, including conflict misses
    do_reset();
    mc_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      mc_lat = tbl[i].lat;
      do_req(tbl[i].addr, tbl[i].hit, $sformatf("vec%0d", i));
    end

    // Controller stall of 5 cycles on byte 2
    do_reset();
    mc_en = 1'b1; mc_lat = 1;
    stall_on = 1'b1; stall_addr = 18'h00012; stall_len = 5; stall_seen = 0;
    do_req(18'h00010, 1'b0, "stall");
    check("stall cycles at 0x12", 32'(stall_seen), 32'd5);
    stall_on = 1'b0;

    // Cancel during byte 1 with no valid: DRAIN swallows the late byte
    do_reset();
    req_in = 1'b1; addr_in = 18'h00010;
    tick();
    req_in = 1'b0;
    check("cancel fill entered", 32'(state_dbg), 32'(S_FILL));
    give_byte(18'h00010);
    check("cancel byte1 addr", 32'(mem_addr_out), 32'h11);
    cancel_in = 1'b1;
    tick();
    cancel_in = 1'b0;
    check("cancel to drain", 32'(state_dbg), 32'(S_DRAIN));
    check("cancel drops mem_req", 32'(mem_req_out), 32'd0);
    req_in = 1'b1; addr_in = 18'h00010;
    tick();
    req_in = 1'b0;
    check("drain ignores req state", 32'(state_dbg), 32'(S_DRAIN));
    check("drain ignores req mem_req", 32'(mem_req_out), 32'd0);
    man_valid = 1'b1; man_data = 8'hFF;
    tick();
    man_valid = 1'b0;
    check("drain late byte to idle", 32'(state_dbg), 32'(S_IDLE));
    check("drain no response", 32'(inst_valid_out), 32'd0);
    tick();
    check("drain still no response", 32'(inst_valid_out), 32'd0);
    mc_en = 1'b1; mc_lat = 0;
    do_req(18'h00010, 1'b0, "after cancel");

    // Cancel with request in the same IDLE cycle
    req_in = 1'b1; cancel_in = 1'b1; addr_in = 18'h00010;
    tick();
    check("cancel+req hit no valid", 32'(inst_valid_out), 32'd0);
    addr_in = 18'h00044;
    tick();
    check("cancel+req miss no mem_req", 32'(mem_req_out), 32'd0);
    check("cancel+req miss idle", 32'(state_dbg), 32'(S_IDLE));
    req_in = 1'b0; cancel_in = 1'b0;
    tick();
    check("cancel+req quiet", 32'(inst_valid_out), 32'd0);

    // Cancel together with the fourth byte: no write, no response
    mc_en = 1'b0;
    req_in = 1'b1; addr_in = 18'h00020;
    tick();
    req_in = 1'b0;
    give_byte(18'h00020);
    give_byte(18'h00021);
    give_byte(18'h00022);
    man_valid = 1'b1; man_data = img[10'h23]; cancel_in = 1'b1;
    tick();
    man_valid = 1'b0; cancel_in = 1'b0;
    check("cancel+last no valid", 32'(inst_valid_out), 32'd0);
    check("cancel+last no mem_req", 32'(mem_req_out), 32'd0);
    check("cancel+last idle", 32'(state_dbg), 32'(S_IDLE));
    mc_en = 1'b1; mc_lat = 1;
    do_req(18'h00020, 1'b0, "after cancel+last");

    // rdy_in low for 3 cycles mid-fill freezes everything
    do_reset();
    exp_q.push_back(img_word(18'h00030));
    req_in = 1'b1; addr_in = 18'h00030;
    tick();
    req_in = 1'b0;
    give_byte(18'h00030);
    rdy_in = 1'b0; man_valid = 1'b1; man_data = 8'hEE; cancel_in = 1'b1;
    req_in = 1'b1; addr_in = 18'h00080;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rdy low mem_req", 32'(mem_req_out), 32'd1);
      check("rdy low mem_addr", 32'(mem_addr_out), 32'h31);
      check("rdy low inst_valid", 32'(inst_valid_out), 32'd0);
      check("rdy low state", 32'(state_dbg), 32'(S_FILL));
    end
    rdy_in = 1'b1; man_valid = 1'b0; cancel_in = 1'b0; req_in = 1'b0;
    give_byte(18'h00031);
    give_byte(18'h00032);
    give_byte(18'h00033);
    check("rdy resume valid", 32'(inst_valid_out), 32'd1);
    check("rdy resume word", inst_out, 32'h00100093);
    tick();
    mc_en = 1'b1; mc_lat = 0;
    do_req(18'h00030, 1'b1, "rdy line hit");

    // Reset mid-fill abandons the fill; a stale byte afterwards is ignored
    mc_en = 1'b0;
    req_in = 1'b1; addr_in = 18'h00040;
    tick();
    req_in = 1'b0;
    give_byte(18'h00040);
    rst_in = 1'b0;
    tick();
    check("midfill reset inst_valid", 32'(inst_valid_out), 32'd0);
    check("midfill reset inst_out", inst_out, 32'd0);
    check("midfill reset mem_req", 32'(mem_req_out), 32'd0);
    check("midfill reset mem_addr", 32'(mem_addr_out), 32'd0);
    check("midfill reset state", 32'(state_dbg), 32'(S_IDLE));
    rst_in = 1'b1; man_valid = 1'b1; man_data = 8'h55;
    tick();
    man_valid = 1'b0;
    check("stale byte no valid", 32'(inst_valid_out), 32'd0);
    check("stale byte no mem_req", 32'(mem_req_out), 32'd0);
    check("stale byte idle", 32'(state_dbg), 32'(S_IDLE));
    mc_en = 1'b1; mc_lat = 1;
    do_req(18'h00030, 1'b0, "post reset 0x30");
    do_req(18'h00040, 1'b0, "post reset 0x40");

    tick();
    tick();
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
